// File: rtl/mmio_responder.sv
// MMIO responder beside dmem: 4-word I/O window (TXDATA, STATUS, CYCLE, SCRATCH), 1-cycle registered reads.
// Build option: define MMIO_IRQ_EN to enable the STATUS.irq_en bit and a registered irq output.

module mmio_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_vld,
  input  logic [W-1:0]  in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [W-1:0]  out_dat,
  input  logic          out_rdy,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign out_vld = (cnt_q != '0);
  assign pop     = out_vld && out_rdy;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign in_rdy  = !full || pop;
  assign push    = in_vld && in_rdy;
  assign out_dat = out_vld ? mem_q[rd_q] : '0;
  assign count     = cnt_q;
  assign count_nxt = cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = in_dat;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module mmio_responder #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] IO_BASE    = 12'hF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_mmio,
  output logic              sel_mmio,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              hit;
  logic [1:0]        off;
  logic              wr_tx, wr_status, wr_cycle, wr_scratch;
  logic              tx_rdy, fifo_full;
  logic [CW-1:0]     fifo_count, fifo_count_nxt;
  logic [DATA_W-1:0] status;
  logic              irq_en;

  logic [DATA_W-1:0] q_mmio_q, q_mmio_d;
  logic              sel_mmio_q, sel_mmio_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;

  assign hit        = (address_dmem[ADDR_W-1:2] == IO_BASE[ADDR_W-1:2]);
  assign off        = address_dmem[1:0];
  assign wr_tx      = hit && wren && (off == 2'd0);
  assign wr_status  = hit && wren && (off == 2'd1);
  assign wr_cycle   = hit && wren && (off == 2'd2);
  assign wr_scratch = hit && wren && (off == 2'd3);

  mmio_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_vld    (wr_tx),
    .in_dat    (data),
    .in_rdy    (tx_rdy),
    .out_vld   (out_valid),
    .out_dat   (out_data),
    .out_rdy   (out_ready),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full)
  );

`ifdef MMIO_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_status) irq_en_d = data[3];
    // Built from next-state values so irq tracks the registered condition with no extra lag.
    irq_d = irq_en_d && ((fifo_count_nxt == '0) || ovf_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^fifo_count_nxt;
  assign irq_en     = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    status       = '0;
    status[15:8] = 8'(fifo_count);
    status[3]    = irq_en;
    status[2]    = ovf_q;
    status[1]    = fifo_full;
    status[0]    = !out_valid;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_tx && !tx_rdy) ovf_d = 1'b1;
    if (wr_status && data[2]) ovf_d = 1'b0;

    cycle_d   = wr_cycle ? data : cycle_q + DATA_W'(1);
    scratch_d = wr_scratch ? data : scratch_q;

    // CYCLE reads return the value the counter holds when q_mmio becomes visible.
    q_mmio_d = '0;
    if (hit) begin
      case (off)
        2'd1:    q_mmio_d = status;
        2'd2:    q_mmio_d = cycle_d;
        2'd3:    q_mmio_d = scratch_q;
        default: q_mmio_d = '0;
      endcase
    end
    sel_mmio_d = hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_mmio_q   <= '0;
      sel_mmio_q <= 1'b0;
      ovf_q      <= 1'b0;
      cycle_q    <= '0;
      scratch_q  <= '0;
    end else begin
      q_mmio_q   <= q_mmio_d;
      sel_mmio_q <= sel_mmio_d;
      ovf_q      <= ovf_d;
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
    end
  end

  assign q_mmio   = q_mmio_q;
  assign sel_mmio = sel_mmio_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus randomized traffic against a queue-based model.

module tb_mmio_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_mmio;
  logic        sel_mmio;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_mmio       (q_mmio),
    .sel_mmio     (sel_mmio),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .irq          (irq)
  );

  // Reference model state
  logic [31:0] m_fifo[$];
  logic        m_ovf = 1'b0;
  logic        m_irq_en = 1'b0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_scr = '0;
  logic [31:0] m_q = '0;
  logic        m_sel = 1'b0;
  logic        m_irq = 1'b0;

  task automatic tick();
    logic       hit;
    logic [1:0] off;
    bit         pop, push;
    logic [31:0] st;
    if (reset) begin
      m_fifo.delete();
      m_ovf = 0; m_irq_en = 0; m_cyc = 0; m_scr = 0;
      m_q = 0; m_sel = 0; m_irq = 0;
    end else begin
      hit  = (address_dmem[11:2] == 10'h3C0);
      off  = address_dmem[1:0];
      pop  = (m_fifo.size() > 0) && out_ready;
      push = 0;
      st = 0;
      st[15:8] = 8'(m_fifo.size());
      st[3] = m_irq_en;
      st[2] = m_ovf;
      st[1] = (m_fifo.size() == 8);
      st[0] = (m_fifo.size() == 0);
      m_cyc = (hit && wren && off == 2'd2) ? data : m_cyc + 32'd1;
      m_q = 0;
      if (hit) begin
        case (off)
          2'd1: m_q = st;
          2'd2: m_q = m_cyc;
          2'd3: m_q = m_scr;
          default: m_q = 0;
        endcase
      end
      m_sel = hit;
      if (hit && wren) begin
        case (off)
          2'd0: if (m_fifo.size() < 8 || pop) push = 1; else m_ovf = 1;
          2'd1: begin
            if (data[2]) m_ovf = 0;
`ifdef MMIO_IRQ_EN
            m_irq_en = data[3];
`endif
          end
          2'd3: m_scr = data;
          default: ;
        endcase
      end
      if (pop) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(data);
      m_irq = m_irq_en && (m_fifo.size() == 0 || m_ovf);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
    address_dmem = a; data = d; wren = w; out_ready = r;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h0) $display("FAIL reset_q: got %h want 0", q_mmio); else n_pass++;
    n_checks++; if (sel_mmio !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel_mmio); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL reset_out: got %b/%h want 0/0", out_valid, out_data); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    reset = 1'b0;
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h1 || sel_mmio !== 1'b1)
      $display("FAIL reset_status: got %h/%b want 00000001/1", q_mmio, sel_mmio); else n_pass++;
  endtask

  task automatic test_fifo_basic();
    drive(12'hF00, 32'h11, 1'b1, 1'b0);
    drive(12'hF00, 32'h22, 1'b1, 1'b0);
    drive(12'hF00, 32'h33, 1'b1, 1'b0);
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h300) $display("FAIL basic_status: got %h want 00000300", q_mmio); else n_pass++;
    n_checks++; if (out_data !== 32'h11 || out_valid !== 1'b1)
      $display("FAIL basic_head: got %b/%h want 1/00000011", out_valid, out_data); else n_pass++;
    drive(12'h000, 32'h0, 1'b0, 1'b1);
    n_checks++; if (out_data !== 32'h22) $display("FAIL basic_pop1: got %h want 00000022", out_data); else n_pass++;
    drive(12'h000, 32'h0, 1'b0, 1'b1);
    n_checks++; if (out_data !== 32'h33) $display("FAIL basic_pop2: got %h want 00000033", out_data); else n_pass++;
    drive(12'h000, 32'h0, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL basic_empty: got %b/%h want 0/0", out_valid, out_data); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) drive(12'hF00, 32'(i + 1), 1'b1, 1'b0);
    drive(12'hF00, 32'hDEAD, 1'b1, 1'b0);
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h806) $display("FAIL ovf_status: got %h want 00000806", q_mmio); else n_pass++;
    drive(12'hF01, 32'h4, 1'b1, 1'b0);
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h802) $display("FAIL ovf_clear: got %h want 00000802", q_mmio); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_data !== 32'(i + 1))
        $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 32'(i + 1)); else n_pass++;
      drive(12'h000, 32'h0, 1'b0, 1'b1);
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_dead_emitted: got valid %b data %h want 0", out_valid, out_data); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) drive(12'hF00, 32'h90 + 32'(i), 1'b1, 1'b0);
    drive(12'hF00, 32'h99, 1'b1, 1'b1);
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h802) $display("FAIL fpp_status: got %h want 00000802", q_mmio); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_data !== ((i == 7) ? 32'h99 : 32'h91 + 32'(i)))
        $display("FAIL fpp_drain%0d: got %h", i, out_data); else n_pass++;
      drive(12'h000, 32'h0, 1'b0, 1'b1);
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fpp_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_regs();
    drive(12'hF02, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drive(12'hF02, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'hFFFF_FFFF) $display("FAIL cycle_load: got %h want ffffffff", q_mmio); else n_pass++;
    drive(12'h000, 32'h0, 1'b0, 1'b0);
    drive(12'hF02, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h1) $display("FAIL cycle_wrap: got %h want 00000001", q_mmio); else n_pass++;
    drive(12'hF03, 32'hA5A5_A5A5, 1'b1, 1'b0);
    drive(12'hF03, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'hA5A5_A5A5) $display("FAIL scratch: got %h want a5a5a5a5", q_mmio); else n_pass++;
    drive(12'hF00, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h0 || sel_mmio !== 1'b1)
      $display("FAIL txdata_read: got %h/%b want 0/1", q_mmio, sel_mmio); else n_pass++;
    drive(12'h100, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h0 || sel_mmio !== 1'b0)
      $display("FAIL miss_100: got %h/%b want 0/0", q_mmio, sel_mmio); else n_pass++;
    drive(12'hEFF, 32'h0, 1'b0, 1'b0);
    n_checks++; if (sel_mmio !== 1'b0) $display("FAIL miss_eff: got %b want 0", sel_mmio); else n_pass++;
    drive(12'hF07, 32'h0, 1'b0, 1'b0);
    n_checks++; if (sel_mmio !== 1'b0 || q_mmio !== 32'h0)
      $display("FAIL miss_f07: got %h/%b want 0/0", q_mmio, sel_mmio); else n_pass++;
    drive(12'hF03, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'hA5A5_A5A5) $display("FAIL miss_nowrite: got %h want a5a5a5a5", q_mmio); else n_pass++;
  endtask

  task automatic test_irq();
    drive(12'hF01, 32'h8, 1'b1, 1'b0);
`ifdef MMIO_IRQ_EN
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq); else n_pass++;
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h9) $display("FAIL irq_status: got %h want 00000009", q_mmio); else n_pass++;
    drive(12'hF00, 32'h55, 1'b1, 1'b0);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_push: got %b want 0", irq); else n_pass++;
`else
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_tied: got %b want 0", irq); else n_pass++;
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h1) $display("FAIL irq_en_ignored: got %h want 00000001", q_mmio); else n_pass++;
    drive(12'hF00, 32'h55, 1'b1, 1'b0);
`endif
    drive(12'hF00, 32'h66, 1'b1, 1'b0);
    drive(12'hF00, 32'h77, 1'b1, 1'b0);
    drive(12'h000, 32'h0, 1'b0, 1'b1);
    reset = 1'b1;
    drive(12'hF00, 32'h88, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || irq !== 1'b0 || out_data !== 32'h0)
      $display("FAIL midreset: got valid %b irq %b data %h want 0/0/0", out_valid, irq, out_data); else n_pass++;
    reset = 1'b0;
    drive(12'hF01, 32'h0, 1'b0, 1'b0);
    n_checks++; if (q_mmio !== 32'h1) $display("FAIL midreset_status: got %h want 00000001", q_mmio); else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] exp_dat;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 8) a = 12'hF00 | 12'($urandom_range(0, 3));
      else a = 12'($urandom);
      if ($urandom_range(0, 1) == 0) a = 12'hF00;
      drive(a, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
      exp_dat = (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
      n_checks++; if (q_mmio !== m_q || sel_mmio !== m_sel)
        $display("FAIL rnd_read@%0d: got %h/%b want %h/%b", n, q_mmio, sel_mmio, m_q, m_sel); else n_pass++;
      n_checks++; if (out_valid !== (m_fifo.size() != 0) || out_data !== exp_dat)
        $display("FAIL rnd_fifo@%0d: got %b/%h want %b/%h", n, out_valid, out_data, m_fifo.size() != 0, exp_dat); else n_pass++;
      n_checks++; if (irq !== m_irq) $display("FAIL rnd_irq@%0d: got %b want %b", n, irq, m_irq); else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_overflow();
    test_full_push_pop();
    test_regs();
    test_irq();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
